bp_fe_ras_ctrl: RTL and testbench

Return-address-stack controller for the front end, driven by the per-instruction scan result (class, compressed flag) and the fetch PC. It pushes the link address on calls and pops a predicted target on returns. It sits beside the instruction scan logic in the fetch stage and feeds the next-PC mux. Backend redirects flush it; the optional checkpoint support allows restore on misprediction.

---
 rtl/bp_fe_ras_ctrl.sv | 140 ++++++++++++++
 tb/tb_bp_fe_ras_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_ras_ctrl.sv
// bp_fe_ras_ctrl: return-address stack controller for the fetch stage.
// Pushes the link address on calls and pops a predicted target on returns.
// Backend redirects empty the stack.
// Optional feature: define BP_FE_RAS_CKPT_EN to add checkpoint save and restore
// of the stack pointer and count. The default build leaves it out.
module bp_fe_ras_ctrl
  #(parameter int eaddr_width_p = 64
   ,parameter int ras_els_p     = 8
   ,parameter int class_width_p = 3
   )
  (input  logic                     clk_i
  ,input  logic                     reset_i
  ,input  logic                     scan_v_i
  ,input  logic [class_width_p-1:0] scan_class_i
  ,input  logic                     scan_compressed_i
  ,input  logic [eaddr_width_p-1:0] pc_i
  ,input  logic                     flush_i
  ,output logic                     pred_v_o
  ,output logic [eaddr_width_p-1:0] pred_addr_o
  ,output logic                     empty_o
  ,output logic                     full_o
`ifdef BP_FE_RAS_CKPT_EN
  ,input  logic                     ckpt_save_i
  ,input  logic                     ckpt_restore_i
`endif
  );

  localparam int ptr_w_lp = $clog2(ras_els_p);
  localparam int cnt_w_lp = $clog2(ras_els_p + 1);

  // Scan class encodings (bp_fe_instr_scan_class_e ordering)
  localparam logic [class_width_p-1:0] e_rvi_call = class_width_p'(4);
  localparam logic [class_width_p-1:0] e_rvi_ret  = class_width_p'(5);
  localparam logic [cnt_w_lp-1:0]      cnt_max_lp = cnt_w_lp'(ras_els_p);

  // Entry storage is deliberately not reset; count_r decides what is valid
  logic [eaddr_width_p-1:0] mem_r [ras_els_p];
  logic [ptr_w_lp-1:0]      tos_r;
  logic [cnt_w_lp-1:0]      count_r;

  logic [eaddr_width_p-1:0] w_link_addr;
  logic                     w_call;
  logic                     w_ret_hit;
  logic                     w_restore;
  logic                     w_mem_we;
  logic [ptr_w_lp-1:0]      w_tos_n;
  logic [cnt_w_lp-1:0]      w_cnt_n;

`ifdef BP_FE_RAS_CKPT_EN
  logic [ptr_w_lp-1:0]      ckpt_tos_r;
  logic [cnt_w_lp-1:0]      ckpt_cnt_r;
  assign w_restore = ckpt_restore_i;
`else
  assign w_restore = 1'b0;
`endif

  // Link address wraps modulo 2^eaddr_width_p (carry out dropped)
  assign w_link_addr = pc_i + (scan_compressed_i ? eaddr_width_p'(2) : eaddr_width_p'(4));
  assign w_call      = scan_v_i & (scan_class_i == e_rvi_call);
  assign w_ret_hit   = scan_v_i & (scan_class_i == e_rvi_ret) & (count_r != {cnt_w_lp{1'b0}});

  // A prediction is suppressed when the scan update is being discarded
  assign pred_v_o    = w_ret_hit & ~flush_i & ~w_restore;
  assign pred_addr_o = mem_r[tos_r];

  assign empty_o = (count_r == {cnt_w_lp{1'b0}});
  assign full_o  = (count_r == cnt_max_lp);

  // Next pointer/count with priority flush > restore > call > ret
  always_comb begin
    w_tos_n  = tos_r;
    w_cnt_n  = count_r;
    w_mem_we = 1'b0;
    if (flush_i) begin
      w_cnt_n = {cnt_w_lp{1'b0}};
    end
    else if (w_restore) begin
`ifdef BP_FE_RAS_CKPT_EN
      w_tos_n = ckpt_tos_r;
      w_cnt_n = ckpt_cnt_r;
`else
      w_tos_n = tos_r;
      w_cnt_n = count_r;
`endif
    end
    else if (w_call) begin
      // When full, the push lands on the oldest entry and count saturates
      w_tos_n  = tos_r + ptr_w_lp'(1);
      w_mem_we = 1'b1;
      if (count_r == cnt_max_lp) begin
        w_cnt_n = count_r;
      end
      else begin
        w_cnt_n = count_r + cnt_w_lp'(1);
      end
    end
    else if (w_ret_hit) begin
      w_tos_n = tos_r - ptr_w_lp'(1);
      w_cnt_n = count_r - cnt_w_lp'(1);
    end
    else begin
      w_tos_n = tos_r;
      w_cnt_n = count_r;
    end
  end

  // Pointer and count registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tos_r   <= {ptr_w_lp{1'b0}};
      count_r <= {cnt_w_lp{1'b0}};
    end
    else begin
      tos_r   <= w_tos_n;
      count_r <= w_cnt_n;
    end
  end

  // Write the link address into the slot above the current top on a call
  always_ff @(posedge clk_i) begin
    if (w_mem_we & ~reset_i) begin
      mem_r[w_tos_n] <= w_link_addr;
    end
  end

`ifdef BP_FE_RAS_CKPT_EN
  // Checkpoint capture of pre-update pointer/count; restore wins over save
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ckpt_tos_r <= {ptr_w_lp{1'b0}};
      ckpt_cnt_r <= {cnt_w_lp{1'b0}};
    end
    else if (ckpt_save_i & ~ckpt_restore_i) begin
      ckpt_tos_r <= tos_r;
      ckpt_cnt_r <= count_r;
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Self-checking bench for bp_fe_ras_ctrl. The reference model is a plain
// queue of return addresses (newest at the back, at most 8 deep).
module tb_bp_fe_ras_ctrl;

  localparam logic [2:0] C_DEFAULT = 3'd0;
  localparam logic [2:0] C_BRANCH  = 3'd1;
  localparam logic [2:0] C_JAL     = 3'd2;
  localparam logic [2:0] C_CALL    = 3'd4;
  localparam logic [2:0] C_RET     = 3'd5;
  localparam int         DEPTH     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_v;
  logic [2:0]  cls;
  logic        comp;
  logic [63:0] pc;
  logic        flush;
  logic        ckpt_save;
  logic        ckpt_restore;
  logic        pred_v;
  logic [63:0] pred_addr;
  logic        empty;
  logic        full;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] q[$];
  logic [63:0] snap_q[$];
  logic        dir_chk;
  logic [63:0] dir_addr;

  always #5 clk = ~clk;

  bp_fe_ras_ctrl #(.eaddr_width_p(64), .ras_els_p(DEPTH), .class_width_p(3)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .scan_v_i         (scan_v),
    .scan_class_i     (cls),
    .scan_compressed_i(comp),
    .pc_i             (pc),
    .flush_i          (flush),
    .pred_v_o         (pred_v),
    .pred_addr_o      (pred_addr),
    .empty_o          (empty),
    .full_o           (full)
`ifdef BP_FE_RAS_CKPT_EN
   ,.ckpt_save_i      (ckpt_save),
    .ckpt_restore_i   (ckpt_restore)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; scan_v = 1'b0; cls = C_DEFAULT; comp = 1'b0; pc = 64'd0;
    flush = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0; dir_chk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    snap_q.delete();
    @(negedge clk);
  endtask

  // One cycle: drive, check combinational prediction, clock, update model, check flags
  task automatic step(input logic v, input logic [2:0] c, input logic cm,
                      input logic [63:0] p, input logic fl);
    logic        exp_v;
    logic [63:0] link;
    scan_v = v; cls = c; comp = cm; pc = p; flush = fl;
    #2;
    exp_v = v && (c == C_RET) && (q.size() != 0) && !fl && !ckpt_restore;
    chk("pred_v", {63'd0, pred_v}, {63'd0, exp_v});
    if (exp_v) chk("pred_addr", pred_addr, q[$]);
    if (dir_chk) begin
      chk("dir_addr", pred_addr, dir_addr);
      dir_chk = 1'b0;
    end
    @(posedge clk);
    link = p + (cm ? 64'd2 : 64'd4);
    if (ckpt_save && !ckpt_restore) snap_q = q;
    if (fl) q.delete();
    else if (ckpt_restore) q = snap_q;
    else if (v && c == C_CALL) begin
      q.push_back(link);
      if (q.size() > DEPTH) void'(q.pop_front());
    end
    else if (v && c == C_RET && q.size() != 0) void'(q.pop_back());
    #1;
    chk("empty", {63'd0, empty}, {63'd0, q.size() == 0});
    chk("full",  {63'd0, full},  {63'd0, q.size() == DEPTH});
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Idle after reset
    for (int i = 0; i < 5; i++) step(1'b0, C_DEFAULT, 1'b0, 64'd0, 1'b0);

    // Two calls, two rets, underflow ret
    step(1'b1, C_CALL, 1'b0, 64'h8000_0000, 1'b0);
    step(1'b1, C_CALL, 1'b1, 64'h8000_0100, 1'b0);
    dir_chk = 1'b1; dir_addr = 64'h8000_0102;
    step(1'b1, C_RET, 1'b0, 64'h9000_0000, 1'b0);
    dir_chk = 1'b1; dir_addr = 64'h8000_0004;
    step(1'b1, C_RET, 1'b0, 64'h9000_0000, 1'b0);
    step(1'b1, C_RET, 1'b0, 64'h9000_0000, 1'b0);
    chk("empty_after_underflow", {63'd0, empty}, 64'd1);

    // Overflow: 10 calls into 8 entries
    for (int i = 0; i < 10; i++) begin
      step(1'b1, C_CALL, 1'b0, 64'h1000 + 64'(16 * i), 1'b0);
      if (i == 7) chk("full_after_8", {63'd0, full}, 64'd1);
    end
    for (int j = 0; j < 8; j++) begin
      dir_chk = 1'b1; dir_addr = 64'h1094 - 64'(16 * j);
      step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    end
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Flush interactions
    step(1'b1, C_CALL, 1'b0, 64'h5000, 1'b1);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, C_CALL, 1'b0, 64'h6000 + 64'(4 * i), 1'b0);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b1);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Ignored classes and invalid scan
    step(1'b1, C_CALL, 1'b1, 64'h7000, 1'b0);
    step(1'b1, C_BRANCH, 1'b0, 64'h7100, 1'b0);
    step(1'b1, C_JAL, 1'b0, 64'h7200, 1'b0);
    step(1'b1, C_DEFAULT, 1'b0, 64'h7300, 1'b0);
    step(1'b0, C_CALL, 1'b0, 64'h7400, 1'b0);
    step(1'b0, C_RET, 1'b0, 64'h7500, 1'b0);
    dir_chk = 1'b1; dir_addr = 64'h7002;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Link address wraps at the top of the address space
    step(1'b1, C_CALL, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step(1'b1, C_CALL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    dir_chk = 1'b1; dir_addr = 64'h1;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    dir_chk = 1'b1; dir_addr = 64'h0;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Reset mid-operation wins over a concurrent call
    for (int i = 0; i < 3; i++) step(1'b1, C_CALL, 1'b0, 64'hA000 + 64'(8 * i), 1'b0);
    reset = 1'b1; scan_v = 1'b1; cls = C_CALL; pc = 64'hB000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    snap_q.delete();
    chk("empty_after_midreset", {63'd0, empty}, 64'd1);
    @(negedge clk);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [2:0]  c;
      r = $urandom_range(0, 15);
      if (r < 6) c = C_CALL;
      else if (r < 12) c = C_RET;
      else c = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 9) != 0), c, 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, ($urandom_range(0, 24) == 0));
    end

`ifdef BP_FE_RAS_CKPT_EN
    // Checkpoint: 2 calls, save, 3 calls, restore, ret
    do_reset();
    step(1'b1, C_CALL, 1'b0, 64'h2000, 1'b0);
    step(1'b1, C_CALL, 1'b0, 64'h2010, 1'b0);
    ckpt_save = 1'b1;
    step(1'b0, C_DEFAULT, 1'b0, 64'd0, 1'b0);
    ckpt_save = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, C_CALL, 1'b0, 64'h3000 + 64'(16 * i), 1'b0);
    ckpt_restore = 1'b1;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    ckpt_restore = 1'b0;
    dir_chk = 1'b1; dir_addr = 64'h2014;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);

    // Save and restore together keep the older checkpoint
    do_reset();
    step(1'b1, C_CALL, 1'b0, 64'h4000, 1'b0);
    ckpt_save = 1'b1;
    step(1'b0, C_DEFAULT, 1'b0, 64'd0, 1'b0);
    step(1'b1, C_CALL, 1'b0, 64'h4100, 1'b0);
    ckpt_restore = 1'b1;
    step(1'b0, C_DEFAULT, 1'b0, 64'd0, 1'b0);
    ckpt_save = 1'b0;
    ckpt_restore = 1'b0;
    step(1'b1, C_CALL, 1'b0, 64'h4200, 1'b0);
    ckpt_restore = 1'b1;
    step(1'b0, C_DEFAULT, 1'b0, 64'd0, 1'b0);
    ckpt_restore = 1'b0;
    dir_chk = 1'b1; dir_addr = 64'h4004;
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
    step(1'b1, C_RET, 1'b0, 64'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
